// File: rtl/sc_io_peripheral_pkg.sv
// Shared definitions for sc_io_peripheral: 7-seg glyphs, port bit-field positions
// and the nibble-to-segment decoder.
package sc_io_peripheral_pkg;

  // Active-low segments, bit order gfedcba.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // in_port1 fields
  localparam int EVT_LSB   = 0;
  localparam int LVL_LSB   = 8;
  localparam int ANY_BIT   = 31;
  // out_port1 fields
  localparam int CLR_LSB   = 0;
  localparam int BLANK_LSB = 16;
  localparam int ACK_BIT   = 31;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    return SEG_0;
      4'h1:    return SEG_1;
      4'h2:    return SEG_2;
      4'h3:    return SEG_3;
      4'h4:    return SEG_4;
      4'h5:    return SEG_5;
      4'h6:    return SEG_6;
      4'h7:    return SEG_7;
      4'h8:    return SEG_8;
      4'h9:    return SEG_9;
      4'hA:    return SEG_A;
      4'hB:    return SEG_B;
      4'hC:    return SEG_C;
      4'hD:    return SEG_D;
      4'hE:    return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/sc_io_peripheral_debounce.sv
// One-bit synchroniser and debouncer: the stable output follows the synchronised
// input only after it has differed for DEBOUNCE_CYCLES consecutive clocks.
module sc_io_peripheral_debounce #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw,
  output logic stable
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // NOTE: all state here updates with <= so every flop samples the pre-edge
  // values; blocking assignments would collapse the synchroniser into one stage.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1  <= RST_VAL;
      sync2  <= RST_VAL;
      stable <= RST_VAL;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sc_io_peripheral.sv
// Board-side I/O partner of sc_computer: debounced switches/keys with sticky key
// events and a toggle-based ack/clear handshake, plus registered 7-seg decode.
module sc_io_peripheral
  import sc_io_peripheral_pkg::*;
#(
  parameter int N_SW            = 10,
  parameter int N_KEY           = 4,
  parameter int N_HEX           = 6,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [N_SW-1:0]    sw,
  input  logic [N_KEY-1:0]   key_n,
  input  logic [31:0]        out_port0,
  input  logic [31:0]        out_port1,
  output logic [31:0]        in_port0,
  output logic [31:0]        in_port1,
  output logic [7*N_HEX-1:0] hex
);

  logic [N_SW-1:0]    sw_db;
  logic [N_KEY-1:0]   key_db;
  logic [N_KEY-1:0]   key_db_q;
  logic [N_KEY-1:0]   key_evt;
  logic               ack_prev;

  logic [N_KEY-1:0]   key_fall;
  logic [N_KEY-1:0]   clr_mask;
  logic [N_KEY-1:0]   evt_next;
  logic [31:0]        port0_next;
  logic [31:0]        port1_next;
  logic [7*N_HEX-1:0] hex_next;

  for (genvar s = 0; s < N_SW; s++) begin : g_sw
    sc_io_peripheral_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RST_VAL        (1'b0)
    ) u_db (
      .clock (clock),
      .resetn(resetn),
      .raw   (sw[s]),
      .stable(sw_db[s])
    );
  end

  for (genvar k = 0; k < N_KEY; k++) begin : g_key
    sc_io_peripheral_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RST_VAL        (1'b1)
    ) u_db (
      .clock (clock),
      .resetn(resetn),
      .raw   (key_n[k]),
      .stable(key_db[k])
    );
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    key_fall = key_db_q & ~key_db;
    clr_mask = '0;
    // The clear mask only acts on the cycle where the CPU has flipped the ack bit.
    if (out_port1[ACK_BIT] != ack_prev) clr_mask = out_port1[CLR_LSB +: N_KEY];
    // Set is OR-ed in after the clear so a coincident press is never lost.
    evt_next = (key_evt & ~clr_mask) | key_fall;

    port0_next             = '0;
    port0_next[N_SW-1:0]   = sw_db;

    port1_next                    = '0;
    port1_next[EVT_LSB +: N_KEY]  = evt_next;
    port1_next[LVL_LSB +: N_KEY]  = ~key_db;
    port1_next[ANY_BIT]           = |evt_next;

    hex_next = '1;
    for (int i = 0; i < N_HEX; i++) begin
      hex_next[7*i +: 7] = out_port1[BLANK_LSB + i] ? SEG_BLANK
                                                    : seg_decode(out_port0[4*i +: 4]);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_db_q <= '1;
      key_evt  <= '0;
      ack_prev <= 1'b0;
      in_port0 <= '0;
      in_port1 <= '0;
      hex      <= '1;
    end else begin
      key_db_q <= key_db;
      key_evt  <= evt_next;
      ack_prev <= out_port1[ACK_BIT];
      in_port0 <= port0_next;
      in_port1 <= port1_next;
      hex      <= hex_next;
    end
  end

endmodule

// File: tb/tb_sc_io_peripheral.sv
// Scoreboard bench for sc_io_peripheral with DEBOUNCE_CYCLES=4: stimulus queues
// expected port values due at a given cycle, a negedge monitor checks them.
module tb_sc_io_peripheral;

  localparam int N_SW  = 10;
  localparam int N_KEY = 4;
  localparam int N_HEX = 6;
  localparam int DC    = 4;
  localparam int LAT   = DC + 3;

  typedef enum logic [1:0] {P_IN0, P_IN1, P_HEX} port_e;
  typedef struct {
    int          due;
    port_e       port;
    logic [63:0] val;
    string       name;
  } exp_t;

  logic               clock = 1'b0;
  logic               resetn;
  logic [N_SW-1:0]    sw;
  logic [N_KEY-1:0]   key_n;
  logic [31:0]        out_port0;
  logic [31:0]        out_port1;
  logic [31:0]        in_port0;
  logic [31:0]        in_port1;
  logic [7*N_HEX-1:0] hex;

  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  // Hand-computed display words, digit 5 down to digit 0.
  localparam logic [41:0] HEX_DARK  = 42'h3FF_FFFF_FFFF;
  localparam logic [41:0] HEX_ZEROS = {6{7'h40}};
  localparam logic [41:0] HEX_ABC1B3 = {7'h08, 7'h03, 7'h46, 7'h79, 7'h7F, 7'h30};

  sc_io_peripheral #(
    .N_SW(N_SW), .N_KEY(N_KEY), .N_HEX(N_HEX), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .sw       (sw),
    .key_n    (key_n),
    .out_port0(out_port0),
    .out_port1(out_port1),
    .in_port0 (in_port0),
    .in_port1 (in_port1),
    .hex      (hex)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic expect_at(input int dly, input port_e p, input logic [63:0] v,
                           input string name);
    exp_t e;
    e.due = cyc + dly; e.port = p; e.val = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: compare every expectation that falls due on this cycle.
  always @(negedge clock) begin
    logic [63:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        case (sb[i].port)
          P_IN0:   act = {32'h0, in_port0};
          P_IN1:   act = {32'h0, in_port1};
          default: act = {22'h0, hex};
        endcase
        n_tests++;
        if (sb[i].due < cyc) begin
          n_fail++;
          $display("FAIL %s: expectation for cycle %0d missed (now %0d)",
                   sb[i].name, sb[i].due, cyc);
        end else if (act !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s: cycle %0d got %h expected %h", sb[i].name, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    resetn = 1'b0; sw = '0; key_n = '1; out_port0 = '0; out_port1 = '0;
    tick(2);
    expect_at(0, P_IN0, 64'h0, "por_in0");
    expect_at(0, P_IN1, 64'h0, "por_in1");
    expect_at(0, P_HEX, {22'h0, HEX_DARK}, "por_hex");
    tick(1);
    resetn = 1'b1;
    expect_at(1, P_HEX, {22'h0, HEX_ZEROS}, "hex_zeros");
    tick(3);

    // Switch debounce: exact latency, then a short glitch that must be filtered.
    sw = 10'h2A5;
    expect_at(LAT - 1, P_IN0, 64'h0, "sw_before");
    expect_at(LAT,     P_IN0, 64'h2A5, "sw_after");
    tick(10);
    sw = 10'h2A4;
    expect_at(3, P_IN0, 64'h2A5, "glitch_a");
    expect_at(6, P_IN0, 64'h2A5, "glitch_b");
    expect_at(9, P_IN0, 64'h2A5, "glitch_c");
    tick(3);
    sw = 10'h2A5;
    tick(10);

    // Key 2 press, then release: event stays sticky.
    key_n = 4'b1011;
    expect_at(LAT - 1, P_IN1, 64'h0, "k2_before");
    expect_at(LAT,     P_IN1, 64'h8000_0404, "k2_press");
    tick(9);
    key_n = 4'b1111;
    expect_at(LAT - 1, P_IN1, 64'h8000_0404, "k2_held");
    expect_at(LAT,     P_IN1, 64'h8000_0004, "k2_release");
    tick(9);

    // Key 0 press/release to build key_evt = 0101.
    key_n = 4'b1110;
    expect_at(LAT, P_IN1, 64'h8000_0105, "k0_press");
    tick(9);
    key_n = 4'b1111;
    expect_at(LAT, P_IN1, 64'h8000_0005, "k0_release");
    tick(9);

    // Ack toggle 0->1 clears key 0 once; holding does nothing; toggle back clears key 2.
    out_port1 = 32'h8000_0001;
    expect_at(1,  P_IN1, 64'h8000_0004, "ack_clr0");
    expect_at(5,  P_IN1, 64'h8000_0004, "ack_hold5");
    expect_at(10, P_IN1, 64'h8000_0004, "ack_hold10");
    tick(10);
    out_port1 = 32'h0000_0004;
    expect_at(1, P_IN1, 64'h0, "ack_clr2");
    tick(3);

    // Debounced press of key 1 on the same edge as a toggle clearing bit 1.
    key_n = 4'b1101;
    tick(LAT - 1);
    out_port1 = 32'h8000_0002;
    expect_at(1, P_IN1, 64'h8000_0202, "set_wins");
    expect_at(2, P_IN1, 64'h8000_0202, "set_wins_hold");
    tick(3);
    key_n = 4'b1111;
    expect_at(LAT, P_IN1, 64'h8000_0002, "k1_release");
    tick(9);

    // Display with digit 1 blanked; the ack flip here carries an empty mask.
    expect_at(0, P_HEX, {22'h0, HEX_ZEROS}, "hex_prev");
    out_port0 = 32'h00AB_C123;
    out_port1 = 32'h0002_0000;
    expect_at(1, P_HEX, {22'h0, HEX_ABC1B3}, "hex_digits");
    expect_at(1, P_IN1, 64'h8000_0002, "empty_mask");
    tick(3);

    // Mid-run reset: outputs drop with no clock edge, debounce restarts from scratch.
    resetn = 1'b0;
    #1;
    expect_at(0, P_IN0, 64'h0, "mid_rst_in0");
    expect_at(0, P_IN1, 64'h0, "mid_rst_in1");
    expect_at(0, P_HEX, {22'h0, HEX_DARK}, "mid_rst_hex");
    tick(2);
    resetn = 1'b1;
    expect_at(1,       P_HEX, {22'h0, HEX_ABC1B3}, "post_rst_hex");
    expect_at(LAT - 1, P_IN0, 64'h0, "post_rst_sw_before");
    expect_at(LAT,     P_IN0, 64'h2A5, "post_rst_sw_after");
    expect_at(LAT,     P_IN1, 64'h0, "post_rst_in1");
    tick(LAT + 3);

    foreach (sb[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: never checked (due cycle %0d)", sb[i].name, sb[i].due);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
